// File: rtl/one_wire_rom_reader.sv
// ----------------------------------------------------------------------------
// one_wire_rom_reader
//
// 1-Wire bus master front end for ROM identification. The sequence is:
// reset pulse, presence check, Read ROM command (CMD_BYTE, LSB first),
// ROM_BITS read slots, then a replay of the captured ROM into the downstream
// one_wire_crc stage at one bit per clk.
//
// Parameters:
//   TICKS_PER_US  clk cycles per microsecond; all slot timing derives from it
//   ROM_BITS      bits read after the command and streamed to the CRC stage
//   CMD_BYTE      command byte sent after presence, LSB first
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset (releases the bus at once)
//   start        in   1-cycle request for one ROM read; ignored while busy
//   ow_in        in   synchronised 1-Wire bus level
//   ow_pull      out  1 = drive bus low (open-drain enable)
//   busy         out  high from accepted start until done / no_presence
//   rom_id       out  captured ROM, bit0 = first bit received
//   rom_valid    out  1-cycle pulse in the cycle after the last streamed bit
//   no_presence  out  1-cycle pulse when no presence pulse was seen
//   crc_start    out  to one_wire_crc.start_crc, high in first stream cycle
//   crc_bit      out  to one_wire_crc.data_stream, rom_id[i] in stream cycle i
//
// Build option:
//   ONE_WIRE_PRESENCE_RETRY_EN  when defined, a missing presence pulse
//   re-runs the reset sequence up to 3 more times (4 attempts in total);
//   no_presence pulses only after the last attempt fails.
// ----------------------------------------------------------------------------
module one_wire_rom_reader #(
    parameter int          TICKS_PER_US = 50,
    parameter int          ROM_BITS     = 64,
    parameter logic [7:0]  CMD_BYTE     = 8'h33
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                ow_in,
    output logic                ow_pull,
    output logic                busy,
    output logic [ROM_BITS-1:0] rom_id,
    output logic                rom_valid,
    output logic                no_presence,
    output logic                crc_start,
    output logic                crc_bit
);

    localparam int TW = $clog2(480 * TICKS_PER_US + 1);
    localparam int BW = (ROM_BITS > 8) ? $clog2(ROM_BITS) : 3;

    // Timer compare points, all in clk ticks
    localparam logic [TW-1:0] T_RESET_END   = TW'(480 * TICKS_PER_US - 1);
    localparam logic [TW-1:0] T_PRES_SAMPLE = TW'(70 * TICKS_PER_US);
    localparam logic [TW-1:0] T_SLOT_END    = TW'(70 * TICKS_PER_US - 1);
    localparam logic [TW-1:0] T_PULL_1      = TW'(6 * TICKS_PER_US);
    localparam logic [TW-1:0] T_PULL_0      = TW'(60 * TICKS_PER_US);
    localparam logic [TW-1:0] T_READ_SAMPLE = TW'(15 * TICKS_PER_US);

    localparam logic [BW-1:0] LAST_CMD_BIT  = BW'(7);
    localparam logic [BW-1:0] LAST_ROM_BIT  = BW'(ROM_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_LOW,
        S_RST_WAIT,
        S_CMD,
        S_READ,
        S_STREAM,
        S_DONE
    } state_t;

    state_t              state_q,    state_d;
    logic [TW-1:0]       timer_q,    timer_d;
    logic [BW-1:0]       bit_cnt_q,  bit_cnt_d;
    logic [ROM_BITS-1:0] rom_id_q,   rom_id_d;
    logic                presence_q, presence_d;
`ifdef ONE_WIRE_PRESENCE_RETRY_EN
    logic [1:0]          attempt_q,  attempt_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            bit_cnt_q  <= '0;
            rom_id_q   <= '0;
            presence_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_cnt_q  <= bit_cnt_d;
            rom_id_q   <= rom_id_d;
            presence_q <= presence_d;
        end
    end

`ifdef ONE_WIRE_PRESENCE_RETRY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            attempt_q <= '0;
        end else begin
            attempt_q <= attempt_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        timer_d     = '0;
        bit_cnt_d   = bit_cnt_q;
        rom_id_d    = rom_id_q;
        presence_d  = presence_q;
`ifdef ONE_WIRE_PRESENCE_RETRY_EN
        attempt_d   = attempt_q;
`endif
        ow_pull     = 1'b0;
        busy        = 1'b1;
        rom_valid   = 1'b0;
        no_presence = 1'b0;
        crc_start   = 1'b0;
        crc_bit     = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = S_RST_LOW;
`ifdef ONE_WIRE_PRESENCE_RETRY_EN
                    attempt_d = '0;
`endif
                end
            end

            S_RST_LOW: begin
                ow_pull = 1'b1;
                timer_d = timer_q + TW'(1);
                if (timer_q == T_RESET_END) begin
                    timer_d = '0;
                    state_d = S_RST_WAIT;
                end
            end

            S_RST_WAIT: begin
                timer_d = timer_q + TW'(1);
                // Single sample point; a slave holding the bus low here is present
                if (timer_q == T_PRES_SAMPLE) begin
                    presence_d = ~ow_in;
                end
                if (timer_q == T_RESET_END) begin
                    timer_d = '0;
                    if (presence_q) begin
                        state_d   = S_CMD;
                        bit_cnt_d = '0;
                    end else begin
`ifdef ONE_WIRE_PRESENCE_RETRY_EN
                        if (attempt_q != 2'd3) begin
                            attempt_d = attempt_q + 2'd1;
                            state_d   = S_RST_LOW;
                        end else begin
                            no_presence = 1'b1;
                            state_d     = S_IDLE;
                        end
`else
                        no_presence = 1'b1;
                        state_d     = S_IDLE;
`endif
                    end
                end
            end

            S_CMD: begin
                // Write-1 is a short low pulse, write-0 holds low for most of the slot
                ow_pull = (timer_q < (CMD_BYTE[bit_cnt_q[2:0]] ? T_PULL_1 : T_PULL_0));
                timer_d = timer_q + TW'(1);
                if (timer_q == T_SLOT_END) begin
                    timer_d = '0;
                    if (bit_cnt_q == LAST_CMD_BIT) begin
                        state_d   = S_READ;
                        bit_cnt_d = '0;
                        rom_id_d  = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end

            S_READ: begin
                ow_pull = (timer_q < T_PULL_1);
                timer_d = timer_q + TW'(1);
                if (timer_q == T_READ_SAMPLE) begin
                    rom_id_d[bit_cnt_q] = ow_in;
                end
                if (timer_q == T_SLOT_END) begin
                    timer_d = '0;
                    if (bit_cnt_q == LAST_ROM_BIT) begin
                        state_d   = S_STREAM;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end

            S_STREAM: begin
                // Back-to-back bits: the CRC stage counts from crc_start with no gaps
                crc_start = (bit_cnt_q == '0);
                crc_bit   = rom_id_q[bit_cnt_q];
                if (bit_cnt_q == LAST_ROM_BIT) begin
                    state_d   = S_DONE;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end

            S_DONE: begin
                busy      = 1'b0;
                rom_valid = 1'b1;
                state_d   = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rom_id = rom_id_q;

endmodule
